// File: rtl/minitb_ahb_slave_pkg.sv
// Shared AHB-Lite type definitions for the miniTB master and slave.
package minitb_ahb_pkg;

  // Bus transfer type encoding
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Slave data-phase state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } slave_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/minitb_ahb_slave_sram.sv
// Single-clock word array: one write port, one registered read port with
// write-to-read forwarding, and a synchronous clear of every word.
module minitb_ahb_sram #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [addrWidth-1:0] waddr,
  input  logic [dataWidth-1:0] wdata,
  input  logic                 re,
  input  logic [addrWidth-1:0] raddr,
  output logic [dataWidth-1:0] rdata
);

  localparam int DEPTH = 2 ** addrWidth;

  logic [dataWidth-1:0] mem_q [DEPTH];
  logic [dataWidth-1:0] rdata_d;
  logic [dataWidth-1:0] rdata_q;

  // Read data: a same-edge write to the read address wins over the array
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[raddr];
      end
    end
  end

  // Array storage; clear has priority so a write coinciding with it is lost
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data register, held between reads
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/minitb_ahb_slave.sv
// AHB-Lite style memory slave for miniTB bus tests.
// Optional feature macro: MINITB_AHB_SLAVE_WAIT_EN -- when defined, every data
// phase is stretched by WAIT_STATES cycles of hready=0; when undefined the
// wait counter is not built and hready stays 1.
module minitb_ahb_slave
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth   = 8,
  parameter int dataWidth   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic [dataWidth-1:0] hrdata,
  output logic                 hready
);

  slave_state_t         state_q, state_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 accept;
  logic                 complete;

`ifdef MINITB_AHB_SLAVE_WAIT_EN
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Data phase is ready once the wait counter has run down
  always_comb begin
    hready = (state_q != ST_DATA) || (wait_cnt_q == '0);
  end

  // Load counter on acceptance, count down while stalling
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept) begin
      wait_cnt_d = WAIT_INIT;
    end else if ((state_q == ST_DATA) && (wait_cnt_q != '0)) begin
      wait_cnt_d = wait_cnt_q - 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_wait_states;
  assign unused_wait_states = (WAIT_STATES != 0);

  // Every data phase completes in a single cycle
  always_comb begin
    hready = 1'b1;
  end
`endif

  // Transfer acceptance, phase completion, next state and captured controls
  always_comb begin
    accept   = hready && (htrans == HTRANS_NONSEQ);
    complete = (state_q == ST_DATA) && hready;
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_DATA;
      ST_DATA: if (complete) state_d = accept ? ST_DATA : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      addr_d  = haddr;
      write_d = hwrite;
    end
  end

  // FSM and address-phase control registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  minitb_ahb_sram #(
    .addrWidth(addrWidth),
    .dataWidth(dataWidth)
  ) u_sram (
    .clk  (hclk),
    .clr  (hreset),
    .we   (complete && write_q),
    .waddr(addr_q),
    .wdata(hwdata),
    .re   (accept && !hwrite),
    .raddr(haddr),
    .rdata(hrdata)
  );

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Directed self-checking bench for minitb_ahb_slave.
module tb_minitb_ahb_slave;

`ifdef MINITB_AHB_SLAVE_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        hclk;
  logic        hreset;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;

  int checks = 0;
  int errors = 0;

  minitb_ahb_slave #(
    .addrWidth  (8),
    .dataWidth  (32),
    .WAIT_STATES(W)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .htrans(htrans),
    .haddr (haddr),
    .hwrite(hwrite),
    .hwdata(hwdata),
    .hrdata(hrdata),
    .hready(hready)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    htrans = 2'b00;
    haddr  = 8'h00;
    hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [7:0] a);
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
  endtask

  // Walk through wait cycles of a data phase, ending on its hready=1 cycle
  task automatic wait_data(input string tag);
    for (int i = 0; i < W; i++) begin
      check({tag, "_wait"}, {31'd0, hready}, 32'd0);
      tick();
    end
    check({tag, "_ready"}, {31'd0, hready}, 32'd1);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    addr_phase(1'b1, a);
    tick();
    bus_idle();
    hwdata = d;
    wait_data("wr");
    tick();
  endtask

  task automatic read_word(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr_phase(1'b0, a);
    tick();
    bus_idle();
    wait_data(tag);
    check(tag, hrdata, exp);
    tick();
  endtask

  initial begin
    hreset = 1'b1;
    hwdata = 32'h0;
    bus_idle();
    tick();
    tick();
    hreset = 1'b0;
    check("rst_hready", {31'd0, hready}, 32'd1);
    check("rst_hrdata", hrdata, 32'h0);
    read_word("rd_10_reset", 8'h10, 32'h0000_0000);

    // Single write then read
    write_word(8'h3C, 32'hDEAD_BEEF);
    read_word("rd_3c", 8'h3C, 32'hDEAD_BEEF);

    // Back-to-back write then read of same address: forwarding
    addr_phase(1'b1, 8'h01);
    tick();
    addr_phase(1'b0, 8'h01);
    hwdata = 32'h0000_0011;
    wait_data("b2b_wr");
    tick();
    bus_idle();
    hwdata = 32'hFFFF_FFFF;
    wait_data("b2b_rd");
    check("b2b_fwd", hrdata, 32'h0000_0011);
    tick();

    // hrdata holds across idle cycles and an intervening write
    tick();
    check("hold_idle", hrdata, 32'h0000_0011);
    write_word(8'h02, 32'h0000_0022);
    check("hold_wr", hrdata, 32'h0000_0011);
    read_word("rd_01", 8'h01, 32'h0000_0011);

    // Write 0x0A completes at the edge a read of 0x3C is accepted
    addr_phase(1'b1, 8'h0A);
    tick();
    addr_phase(1'b0, 8'h3C);
    hwdata = 32'hCAFE_F00D;
    wait_data("ind_wr");
    tick();
    bus_idle();
    wait_data("ind_rd");
    check("ind_rd_3c", hrdata, 32'hDEAD_BEEF);
    tick();
    read_word("rd_0a", 8'h0A, 32'hCAFE_F00D);

    // BUSY / SEQ / IDLE with write controls must not transfer
    hwrite = 1'b1;
    haddr  = 8'h07;
    hwdata = 32'h7777_7777;
    htrans = 2'b01;
    tick();
    check("busy_hready", {31'd0, hready}, 32'd1);
    htrans = 2'b11;
    tick();
    check("seq_hready", {31'd0, hready}, 32'd1);
    htrans = 2'b00;
    tick();
    tick();
    bus_idle();
    read_word("rd_07", 8'h07, 32'h0000_0000);

    // Top of address range
    write_word(8'hFF, 32'h55AA_33CC);
    read_word("rd_ff", 8'hFF, 32'h55AA_33CC);
    read_word("rd_00", 8'h00, 32'h0000_0000);

`ifdef MINITB_AHB_SLAVE_WAIT_EN
    write_word(8'h05, 32'hA5A5_A5A5);
    read_word("rd_05", 8'h05, 32'hA5A5_A5A5);
`endif

    // Reset during a write data phase drops the write and clears the array
    addr_phase(1'b1, 8'h20);
    tick();
    bus_idle();
    hwdata = 32'h1234_5678;
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    check("mid_rst_hready", {31'd0, hready}, 32'd1);
    check("mid_rst_hrdata", hrdata, 32'h0);
    read_word("rd_20", 8'h20, 32'h0000_0000);
    read_word("rd_3c_clr", 8'h3C, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
